// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light countdown generator:
// phase encodings and the saturating binary-to-BCD helper used by the display outputs.
package traffic_pkg;

    // Phase encodings as seen on phase_o
    typedef enum logic [2:0] {
        PH_MG    = 3'd0,
        PH_MY    = 3'd1,
        PH_SG    = 3'd2,
        PH_SY    = 3'd3,
        PH_FLASH = 3'd4
    } phase_e;

    // Two-digit BCD conversion, saturating at 99.
    // Input is zero-extended to 32 bits by the caller (countdown widths up to 32).
    // Result layout: {ovf, tens[3:0], ones[3:0]}.
    function automatic logic [8:0] bin2bcd99(input logic [31:0] v);
        logic [6:0] v7;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [8:0] res;
        v7 = v[6:0];
        if (v > 32'd99) begin
            res = {1'b1, 4'd9, 4'd9};
        end else begin
            tens = 4'(v7 / 7'd10);
            ones = 4'(v7 % 7'd10);
            res  = {1'b0, tens, ones};
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-cycle count tick every CLK_DIV cycles while run is high.
// clr restarts the division from zero; the count freezes (without clearing) while run is low.
module tick_prescaler #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int              PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   P_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;

    // Prescaler counter: clear has priority, otherwise wrap at CLK_DIV-1 while running
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clr) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= (r_presc == P_MAX) ? '0 : (r_presc + PW'(1));
        end else begin
            r_presc <= r_presc;
        end
    end

    // Tick is decoded from the register so it is visible during the last cycle of a period
    assign tick = run & (r_presc == P_MAX);

endmodule

// File: rtl/phase_countdown_gen.sv
// Four-phase traffic-light countdown generator with hold, side-road demand skipping,
// night-flash override and saturating two-digit BCD display outputs.
module phase_countdown_gen
    import traffic_pkg::*;
#(
    parameter int CLK_DIV     = 50,
    parameter int NUM_W       = 8,
    parameter int T_MAIN      = 30,
    parameter int T_MAIN_Y    = 3,
    parameter int T_SIDE      = 15,
    parameter int T_SIDE_Y    = 3,
    parameter int SIDE_DEMAND = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             side_req,
    input  logic             flash_i,
    output logic [NUM_W-1:0] count_o,
    output logic [2:0]       phase_o,
    output logic             tick_o,
    output logic             phase_done,
    output logic             flash_o,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             bcd_ovf
);
    // Load values: a phase of T ticks counts T-1 down to 0
    localparam logic [NUM_W-1:0] LD_MG = NUM_W'(T_MAIN - 1);
    localparam logic [NUM_W-1:0] LD_MY = NUM_W'(T_MAIN_Y - 1);
    localparam logic [NUM_W-1:0] LD_SG = NUM_W'(T_SIDE - 1);
    localparam logic [NUM_W-1:0] LD_SY = NUM_W'(T_SIDE_Y - 1);

    phase_e           r_phase;
    logic [NUM_W-1:0] r_count;
    logic             r_flash;
    logic             r_req;
    logic             r_phase_done;

    phase_e           w_phase_nxt;
    logic [NUM_W-1:0] w_count_nxt;
    logic             w_flash_nxt;
    logic             w_req_nxt;
    logic             w_run;
    logic             w_clr;
    logic             w_tick;
    logic             w_in_flash;
    logic [8:0]       w_bcd;

    assign w_in_flash = (r_phase == PH_FLASH);
    // Prescaler keeps running in FLASH regardless of en so the lamp keeps blinking
    assign w_run      = en | w_in_flash;
    // Entering or leaving FLASH restarts the tick period from zero
    assign w_clr      = flash_i ^ w_in_flash;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Next-state logic: flash override first, then normal countdown and phase sequencing
    always_comb begin
        w_phase_nxt = r_phase;
        w_count_nxt = r_count;
        w_flash_nxt = r_flash;
        w_req_nxt   = r_req;
        if (flash_i && !w_in_flash) begin
            w_phase_nxt = PH_FLASH;
            w_count_nxt = '0;
            w_flash_nxt = 1'b0;
        end else if (!flash_i && w_in_flash) begin
            w_phase_nxt = PH_MG;
            w_count_nxt = LD_MG;
            w_flash_nxt = 1'b0;
            w_req_nxt   = 1'b0;
        end else if (w_in_flash) begin
            if (w_tick) begin
                w_flash_nxt = ~r_flash;
            end else begin
                w_flash_nxt = r_flash;
            end
        end else begin
            // Side requests are captured during the main-road phases even while held
            if (side_req && ((r_phase == PH_MG) || (r_phase == PH_MY))) begin
                w_req_nxt = 1'b1;
            end else begin
                w_req_nxt = r_req;
            end
            if (w_tick) begin
                if (r_count != '0) begin
                    w_count_nxt = r_count - NUM_W'(1);
                end else begin
                    case (r_phase)
                        PH_MG: begin
                            // A request arriving in this very cycle is already in w_req_nxt
                            if ((SIDE_DEMAND != 0) && !w_req_nxt) begin
                                w_phase_nxt = PH_MG;
                                w_count_nxt = LD_MG;
                            end else begin
                                w_phase_nxt = PH_MY;
                                w_count_nxt = LD_MY;
                            end
                        end
                        PH_MY: begin
                            w_phase_nxt = PH_SG;
                            w_count_nxt = LD_SG;
                            w_req_nxt   = 1'b0;
                        end
                        PH_SG: begin
                            w_phase_nxt = PH_SY;
                            w_count_nxt = LD_SY;
                        end
                        PH_SY: begin
                            w_phase_nxt = PH_MG;
                            w_count_nxt = LD_MG;
                        end
                        default: begin
                            w_phase_nxt = PH_MG;
                            w_count_nxt = LD_MG;
                        end
                    endcase
                end
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // State registers; phase_done marks the first cycle a different phase is visible
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= PH_MG;
            r_count      <= LD_MG;
            r_flash      <= 1'b0;
            r_req        <= 1'b0;
            r_phase_done <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_count      <= w_count_nxt;
            r_flash      <= w_flash_nxt;
            r_req        <= w_req_nxt;
            r_phase_done <= (w_phase_nxt != r_phase);
        end
    end

    assign w_bcd      = bin2bcd99(32'(r_count));
    assign count_o    = r_count;
    assign phase_o    = r_phase;
    assign tick_o     = w_tick;
    assign phase_done = r_phase_done;
    assign flash_o    = r_flash;
    assign bcd_ovf    = w_bcd[8];
    assign bcd_tens   = w_bcd[7:4];
    assign bcd_ones   = w_bcd[3:0];

endmodule

// File: tb/tb_phase_countdown_gen.sv
// Bench for phase_countdown_gen: three instances (plain cycling, side-demand, long main
// phase for BCD) share one stimulus stream and are all checked every cycle against a
// behavioural model; directed tables and sequences cover the documented corner cases.
module tb_phase_countdown_gen;
    localparam int CD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, side_req, flash_i;
    logic [7:0] cnt  [3];
    logic [2:0] ph   [3];
    logic       tk   [3];
    logic       pd   [3];
    logic       fl   [3];
    logic       ovf  [3];
    logic [3:0] tens [3];
    logic [3:0] ones [3];

    phase_countdown_gen #(.CLK_DIV(CD), .NUM_W(8), .T_MAIN(5), .T_MAIN_Y(2), .T_SIDE(3),
                          .T_SIDE_Y(1), .SIDE_DEMAND(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .side_req(side_req), .flash_i(flash_i),
        .count_o(cnt[0]), .phase_o(ph[0]), .tick_o(tk[0]), .phase_done(pd[0]),
        .flash_o(fl[0]), .bcd_tens(tens[0]), .bcd_ones(ones[0]), .bcd_ovf(ovf[0]));

    phase_countdown_gen #(.CLK_DIV(CD), .NUM_W(8), .T_MAIN(5), .T_MAIN_Y(2), .T_SIDE(3),
                          .T_SIDE_Y(1), .SIDE_DEMAND(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .side_req(side_req), .flash_i(flash_i),
        .count_o(cnt[1]), .phase_o(ph[1]), .tick_o(tk[1]), .phase_done(pd[1]),
        .flash_o(fl[1]), .bcd_tens(tens[1]), .bcd_ones(ones[1]), .bcd_ovf(ovf[1]));

    phase_countdown_gen #(.CLK_DIV(CD), .NUM_W(8), .T_MAIN(120), .T_MAIN_Y(2), .T_SIDE(3),
                          .T_SIDE_Y(1), .SIDE_DEMAND(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .side_req(side_req), .flash_i(flash_i),
        .count_o(cnt[2]), .phase_o(ph[2]), .tick_o(tk[2]), .phase_done(pd[2]),
        .flash_o(fl[2]), .bcd_tens(tens[2]), .bcd_ones(ones[2]), .bcd_ovf(ovf[2]));

    int total = 0;
    int bad   = 0;

    // Behavioural model state, one slot per instance
    int dur  [3][4];
    int sd   [3];
    int m_ph [3];
    int m_cnt[3];
    int m_ps [3];
    int m_fl [3];
    int m_req[3];
    int m_pd [3];

    typedef struct {
        bit en;
        bit sreq;
        bit fls;
        int ncyc;
        int ph;
        int cnt;
        int pd;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUTs sampled
    task automatic model_edge();
        int  o_ph;
        int  nx;
        bit  t;
        for (int k = 0; k < 3; k++) begin
            o_ph = m_ph[k];
            t = (m_ps[k] == CD - 1) && (en || o_ph == 4);
            if (rst) begin
                m_ph[k] = 0; m_cnt[k] = dur[k][0] - 1; m_ps[k] = 0;
                m_fl[k] = 0; m_req[k] = 0;
            end else if (flash_i && o_ph != 4) begin
                m_ph[k] = 4; m_cnt[k] = 0; m_ps[k] = 0; m_fl[k] = 0;
            end else if (!flash_i && o_ph == 4) begin
                m_ph[k] = 0; m_cnt[k] = dur[k][0] - 1; m_ps[k] = 0;
                m_fl[k] = 0; m_req[k] = 0;
            end else begin
                if (en || o_ph == 4) m_ps[k] = (m_ps[k] + 1) % CD;
                if (o_ph == 4) begin
                    if (t) m_fl[k] = 1 - m_fl[k];
                end else begin
                    if (side_req && o_ph < 2) m_req[k] = 1;
                    if (t) begin
                        if (m_cnt[k] > 0) begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end else begin
                            nx = (o_ph + 1) % 4;
                            if (o_ph == 0 && sd[k] != 0 && m_req[k] == 0) nx = 0;
                            if (nx == 2) m_req[k] = 0;
                            m_ph[k]  = nx;
                            m_cnt[k] = dur[k][nx] - 1;
                        end
                    end
                end
            end
            m_pd[k] = rst ? 0 : ((m_ph[k] != o_ph) ? 1 : 0);
        end
    endtask

    task automatic check_all();
        int et, eo;
        for (int k = 0; k < 3; k++) begin
            chk(k, "count", cnt[k], m_cnt[k]);
            chk(k, "phase", ph[k], m_ph[k]);
            chk(k, "phase_done", pd[k], m_pd[k]);
            chk(k, "flash_o", fl[k], m_fl[k]);
            chk(k, "tick", tk[k], ((m_ps[k] == CD - 1) && (en || m_ph[k] == 4)) ? 1 : 0);
            if (m_cnt[k] > 99) begin et = 9; eo = 9; end
            else begin et = m_cnt[k] / 10; eo = m_cnt[k] % 10; end
            chk(k, "bcd_tens", tens[k], et);
            chk(k, "bcd_ones", ones[k], eo);
            chk(k, "bcd_ovf", ovf[k], (m_cnt[k] > 99) ? 1 : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; side_req = 1'b0; flash_i = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; side_req = 1'b0; flash_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dur[k][0] = (k == 2) ? 120 : 5;
            dur[k][1] = 2; dur[k][2] = 3; dur[k][3] = 1;
            sd[k] = (k == 1) ? 1 : 0;
            m_ph[k] = 0; m_cnt[k] = 0; m_ps[k] = 0; m_fl[k] = 0; m_req[k] = 0; m_pd[k] = 0;
        end

        // Directed timeline for the plain instance: {en, side_req, flash_i, clocks, phase, count, phase_done}
        tbl[0]  = '{1'b1, 1'b0, 1'b0,  1, 0, 4, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0,  3, 0, 3, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 12, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0,  4, 1, 1, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0,  1, 1, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0,  7, 2, 2, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 12, 3, 0, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0,  3, 3, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0,  1, 0, 4, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0,  8, 0, 2, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0,  2, 0, 2, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 10, 0, 2, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b0,  1, 0, 2, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b0,  1, 0, 1, 0};

        do_reset();
        chk(0, "rst_count", cnt[0], 4);
        chk(0, "rst_phase", ph[0], 0);
        chk(0, "rst_phase_done", pd[0], 0);
        chk(0, "rst_flash", fl[0], 0);
        chk(0, "rst_tick", tk[0], 0);
        chk(2, "rst_bcd", {ovf[2], tens[2], ones[2]}, {1'b1, 4'd9, 4'd9});

        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; side_req = tbl[i].sreq; flash_i = tbl[i].fls;
            for (int c = 0; c < tbl[i].ncyc; c++) step();
            chk(0, $sformatf("tbl%0d_phase", i), ph[0], tbl[i].ph);
            chk(0, $sformatf("tbl%0d_count", i), cnt[0], tbl[i].cnt);
            chk(0, $sformatf("tbl%0d_pd", i), pd[0], tbl[i].pd);
        end

        // Side demand: no request reloads MAIN_GO silently; a 1-cycle request is served
        do_reset();
        repeat (20) step();
        chk(1, "sd_reload_phase", ph[1], 0);
        chk(1, "sd_reload_count", cnt[1], 4);
        chk(1, "sd_reload_pd", pd[1], 0);
        repeat (2) step();
        side_req = 1'b1;
        step();
        side_req = 1'b0;
        repeat (17) step();
        chk(1, "sd_my_phase", ph[1], 1);
        chk(1, "sd_my_count", cnt[1], 1);
        chk(1, "sd_my_pd", pd[1], 1);
        repeat (8) step();
        chk(1, "sd_sg_phase", ph[1], 2);
        chk(1, "sd_sg_count", cnt[1], 2);

        // Flash override from SIDE_GO, blinking, release, then reset during flash
        do_reset();
        repeat (28) step();
        chk(0, "pre_flash_phase", ph[0], 2);
        flash_i = 1'b1;
        step();
        chk(0, "flash_phase", ph[0], 4);
        chk(0, "flash_count", cnt[0], 0);
        chk(0, "flash_pd", pd[0], 1);
        chk(0, "flash_o_init", fl[0], 0);
        repeat (4) step();
        chk(0, "flash_o_on", fl[0], 1);
        repeat (4) step();
        chk(0, "flash_o_off", fl[0], 0);
        flash_i = 1'b0;
        step();
        chk(0, "unflash_phase", ph[0], 0);
        chk(0, "unflash_count", cnt[0], 4);
        chk(0, "unflash_pd", pd[0], 1);
        flash_i = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk(0, "rst_in_flash_phase", ph[0], 0);
        chk(0, "rst_in_flash_count", cnt[0], 4);
        chk(0, "rst_in_flash_pd", pd[0], 0);
        rst = 1'b0; flash_i = 1'b0;

        // BCD on the long main phase: 99 and 42
        do_reset();
        repeat (80) step();
        chk(2, "bcd99_count", cnt[2], 99);
        chk(2, "bcd99", {ovf[2], tens[2], ones[2]}, {1'b0, 4'd9, 4'd9});
        repeat (228) step();
        chk(2, "bcd42_count", cnt[2], 42);
        chk(2, "bcd42", {ovf[2], tens[2], ones[2]}, {1'b0, 4'd4, 4'd2});

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            side_req = ($urandom_range(0, 15) == 0);
            if (flash_i) begin
                if ($urandom_range(0, 39) == 0) flash_i = 1'b0;
            end else begin
                if ($urandom_range(0, 299) == 0) flash_i = 1'b1;
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
